// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA scan / logo animation slice.
// Timing defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

  localparam int COORD_W = 11;
  localparam int ARITH_W = COORD_W + 1;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_STEP            = 2;
  localparam int DEF_DELT_MAX        = 80;
  localparam int DEF_FRAMES_PER_STEP = 1;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } dir_t;

  // Half-open window test used by both sync decoders.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_scan_anim_if.sv
// Scan/animation bundle between the timing generator and the logo painters.
interface vga_scan_anim_if;
  import vga_pkg::*;

  logic               en;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               hs;
  logic               vs;
  logic               visible;
  logic               frame_tick;
  logic [COORD_W-1:0] delt;

  modport master (
    input  en,
    output x, y, hs, vs, visible, frame_tick, delt
  );

  modport slave (
    output en,
    input  x, y, hs, vs, visible, frame_tick, delt
  );

endinterface

// File: rtl/logo_bounce_ctrl.sv
// Frame divider plus two-state bounce FSM producing the logo offset delt.
// delt only moves on a qualified step_en edge, so it is constant within a frame.
module logo_bounce_ctrl
  import vga_pkg::*;
#(
  parameter int STEP            = DEF_STEP,
  parameter int DELT_MAX        = DEF_DELT_MAX,
  parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  output logic [COORD_W-1:0] delt
);

  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [ARITH_W-1:0] STEP_W   = ARITH_W'(STEP);
  localparam logic [ARITH_W-1:0] MAX_W    = ARITH_W'(DELT_MAX);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] MAX_C    = COORD_W'(DELT_MAX);

  dir_t               state, state_nxt;
  logic [COORD_W-1:0] delt_q, delt_nxt;
  logic [DIV_W-1:0]   div, div_nxt;

  // One extra bit of headroom so delt+STEP cannot wrap before the clamp test.
  function automatic logic hits_max(input logic [COORD_W-1:0] d);
    logic [ARITH_W-1:0] sum;
    sum = {1'b0, d} + STEP_W;
    return sum >= MAX_W;
  endfunction

  function automatic logic hits_min(input logic [COORD_W-1:0] d);
    return {1'b0, d} <= STEP_W;
  endfunction

  function automatic logic [COORD_W-1:0] step_up(input logic [COORD_W-1:0] d);
    logic [ARITH_W-1:0] sum;
    sum = {1'b0, d} + STEP_W;
    return (sum >= MAX_W) ? MAX_C : sum[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] step_dn(input logic [COORD_W-1:0] d);
    return (d <= STEP_C) ? '0 : (d - STEP_C);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RIGHT;
      delt_q <= '0;
      div    <= '0;
    end else begin
      state  <= state_nxt;
      delt_q <= delt_nxt;
      div    <= div_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    delt_nxt  = delt_q;
    div_nxt   = div;
    if (step_en) begin
      if (div == DIV_LAST) begin
        div_nxt = '0;
        unique case (state)
          RIGHT: begin
            if (hits_max(delt_q)) begin
              delt_nxt  = MAX_C;
              state_nxt = LEFT;
            end else begin
              delt_nxt = step_up(delt_q);
            end
          end
          LEFT: begin
            if (hits_min(delt_q)) begin
              delt_nxt  = '0;
              state_nxt = RIGHT;
            end else begin
              delt_nxt = step_dn(delt_q);
            end
          end
          default: begin
            delt_nxt  = '0;
            state_nxt = RIGHT;
          end
        endcase
      end else begin
        div_nxt = div + 1'b1;
      end
    end
  end

  assign delt = delt_q;

endmodule

// File: rtl/vga_scan_anim.sv
// VGA scan counters with zero-latency sync/visible/frame_tick decode,
// plus the per-frame logo offset from logo_bounce_ctrl.
module vga_scan_anim
  import vga_pkg::*;
#(
  parameter int H_VIS           = DEF_H_VIS,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_VIS           = DEF_V_VIS,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter int STEP            = DEF_STEP,
  parameter int DELT_MAX        = DEF_DELT_MAX,
  parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
  input  logic            clk,
  input  logic            rst,
  vga_scan_anim_if.master vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VIS);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC);

  logic [COORD_W-1:0] hcnt, vcnt;
  logic               h_last, v_last, frame_tick;

  assign h_last     = (hcnt == H_LAST);
  assign v_last     = (vcnt == V_LAST);
  assign frame_tick = h_last && v_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : (vcnt + 1'b1);
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Decodes come straight off the counters so they line up with x/y.
  assign vga.x          = hcnt;
  assign vga.y          = vcnt;
  assign vga.hs         = ~in_window(hcnt, HS_START, HS_END);
  assign vga.vs         = ~in_window(vcnt, VS_START, VS_END);
  assign vga.visible    = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
  assign vga.frame_tick = frame_tick;

  logo_bounce_ctrl #(
    .STEP            (STEP),
    .DELT_MAX        (DELT_MAX),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_bounce (
    .clk     (clk),
    .rst     (rst),
    .step_en (frame_tick & vga.en),
    .delt    (vga.delt)
  );

endmodule

// File: tb/tb_vga_scan_anim.sv
// Directed bench: full-timing line checks plus reduced-timing instances
// (16x10 frame) exercising frame decode, bounce, enable hold and async reset.
module tb_vga_scan_anim;

  localparam int SH_VIS = 8, SH_FP = 2, SH_SYNC = 3, SH_BP = 3;  // 16 per line
  localparam int SV_VIS = 6, SV_FP = 1, SV_SYNC = 2, SV_BP = 1;  // 10 lines

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_assert;
  int   n_fail;
  int   cyc;

  vga_scan_anim_if if0 ();
  vga_scan_anim_if if1 ();
  vga_scan_anim_if if2 ();
  vga_scan_anim_if if3 ();
  vga_scan_anim_if if4 ();
  vga_scan_anim_if if5 ();
  vga_scan_anim_if if6 ();

  vga_scan_anim u0 (.clk(clk), .rst(rst_a), .vga(if0));

  vga_scan_anim #(.H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
                  .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
                  .STEP(2), .DELT_MAX(80), .FRAMES_PER_STEP(1))
    u1 (.clk(clk), .rst(rst_a), .vga(if1));

  vga_scan_anim #(.H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
                  .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
                  .STEP(3), .DELT_MAX(80), .FRAMES_PER_STEP(1))
    u2 (.clk(clk), .rst(rst_a), .vga(if2));

  vga_scan_anim #(.H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
                  .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
                  .STEP(2), .DELT_MAX(80), .FRAMES_PER_STEP(1))
    u3 (.clk(clk), .rst(rst_a), .vga(if3));

  vga_scan_anim #(.H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
                  .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
                  .STEP(2), .DELT_MAX(80), .FRAMES_PER_STEP(4))
    u4 (.clk(clk), .rst(rst_a), .vga(if4));

  vga_scan_anim #(.H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
                  .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
                  .STEP(2), .DELT_MAX(80), .FRAMES_PER_STEP(1))
    u5 (.clk(clk), .rst(rst_b), .vga(if5));

  vga_scan_anim #(.H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
                  .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
                  .STEP(0), .DELT_MAX(80), .FRAMES_PER_STEP(1))
    u6 (.clk(clk), .rst(rst_a), .vga(if6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // cyc = number of rising edges since reset release; sampling is on negedges.
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int hs_low, vis1, vs1_low, tick1, x1, y1;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    hs_low   = 0;
    vis1     = 0;
    vs1_low  = 0;
    tick1    = 0;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    if0.en = 1'b1; if1.en = 1'b1; if2.en = 1'b1; if3.en = 1'b1;
    if4.en = 1'b1; if5.en = 1'b1; if6.en = 1'b1;

    #1;
    chk("rst_x", if0.x, 0);
    chk("rst_y", if0.y, 0);
    chk("rst_hs", if0.hs, 1);
    chk("rst_vs", if0.vs, 1);
    chk("rst_visible", if0.visible, 1);
    chk("rst_frame_tick", if0.frame_tick, 0);
    chk("rst_delt", if0.delt, 0);

    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int k = 0; k <= 800; k++) begin
      wait_cyc(k);
      chk("u0_x", if0.x, k % 800);
      chk("u0_y", if0.y, k / 800);
      chk("u0_hs", if0.hs, ((k % 800) >= 656 && (k % 800) < 752) ? 0 : 1);
      chk("u0_visible", if0.visible, ((k % 800) < 640) ? 1 : 0);
      if (k < 800 && !if0.hs) hs_low++;
      if (k < 160) begin
        x1 = k % 16;
        y1 = k / 16;
        chk("u1_vs", if1.vs, (y1 == 7 || y1 == 8) ? 0 : 1);
        chk("u1_frame_tick", if1.frame_tick, (x1 == 15 && y1 == 9) ? 1 : 0);
        chk("u1_delt_frame0", if1.delt, 0);
        if (if1.frame_tick) tick1++;
        if (if1.visible) vis1++;
        if (!if1.vs) vs1_low++;
      end
      if (k == 16) begin
        chk("u1_hwrap_x", if1.x, 0);
        chk("u1_hwrap_y", if1.y, 1);
      end
      if (k == 160) begin
        chk("u1_fwrap_x", if1.x, 0);
        chk("u1_fwrap_y", if1.y, 0);
        chk("u1_delt_t1", if1.delt, 2);
      end
      if (k == 480) chk("u4_delt_t3", if4.delt, 0);
      if (k == 640) chk("u4_delt_t4", if4.delt, 2);
    end
    chk("u0_hs_low_cycles", hs_low, 96);
    chk("u1_ticks_per_frame", tick1, 1);
    chk("u1_visible_cycles", vis1, 48);
    chk("u1_vs_low_cycles", vs1_low, 32);
    chk("u3_delt_t5", if3.delt, 10);
    chk("u6_step0_delt", if6.delt, 0);

    wait_cyc(810);
    if3.en = 1'b0;
    wait_cyc(1100); chk("u3_hold_mid", if3.delt, 10);
    wait_cyc(1120); chk("u4_delt_t7", if4.delt, 2);
    wait_cyc(1280); chk("u4_delt_t8", if4.delt, 4);
    wait_cyc(1600); chk("u3_hold_5ticks", if3.delt, 10);
    wait_cyc(1610);
    if3.en = 1'b1;
    wait_cyc(1759); chk("u3_before_resume", if3.delt, 10);
    wait_cyc(1760); chk("u3_resume", if3.delt, 12);

    wait_cyc(3200); chk("u5_delt_t20", if5.delt, 40);
    wait_cyc(3235);
    chk("u5_pre_x", if5.x, 3);
    chk("u5_pre_y", if5.y, 2);
    #2;
    rst_b = 1'b1;
    #1;
    chk("u5_arst_x", if5.x, 0);
    chk("u5_arst_y", if5.y, 0);
    chk("u5_arst_delt", if5.delt, 0);
    chk("u5_arst_hs", if5.hs, 1);
    chk("u5_arst_vs", if5.vs, 1);
    wait_cyc(3237);
    rst_b = 1'b0;
    chk("u5_rel_x", if5.x, 0);
    wait_cyc(3238);
    chk("u5_restart_x", if5.x, 1);
    chk("u5_restart_y", if5.y, 0);
    chk("u5_restart_delt", if5.delt, 0);

    wait_cyc(4160); chk("u2_delt_t26", if2.delt, 78);
    wait_cyc(4320); chk("u2_delt_t27", if2.delt, 80);
    wait_cyc(4480); chk("u2_delt_t28", if2.delt, 77);

    wait_cyc(6399);
    chk("u1_delt_t39", if1.delt, 78);
    chk("u1_tick_t40", if1.frame_tick, 1);
    wait_cyc(6400); chk("u1_delt_t40", if1.delt, 80);
    wait_cyc(6559); chk("u1_delt_hold_t40", if1.delt, 80);
    wait_cyc(6560); chk("u1_delt_t41", if1.delt, 78);
    wait_cyc(12800); chk("u1_delt_t80", if1.delt, 0);
    wait_cyc(12960); chk("u1_delt_t81", if1.delt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_anim.md
Name: vga_scan_anim

Overview:
- Upstream source for the logo painters. Generates 640x480@60 VGA scan timing: pixel coordinates x/y, hsync/vsync and a visible flag.
- Also produces the per-frame horizontal logo offset `delt`, which bounces between 0 and DELT_MAX.
- Painter blocks consume x, y and delt combinationally and return hit. The colour mux gates hit with visible.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- STEP, 2, delt increment per animation step
- DELT_MAX, 80, upper bound of delt
- FRAMES_PER_STEP, 1, frames between animation steps (>=1)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous, active-high reset
- en  in  1  animation enable; scan timing always runs
- x  out  11  current horizontal count, 0..H_TOTAL-1
- y  out  11  current vertical count, 0..V_TOTAL-1
- hs  out  1  hsync, active low
- vs  out  1  vsync, active low
- visible  out  1  high when x<H_VIS and y<V_VIS
- frame_tick  out  1  one-cycle pulse on the last pixel of a frame
- delt  out  11  logo offset, 0..DELT_MAX

Behaviour:
- Derived constants: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- Reset (async, rst=1) forces: hcnt=0, vcnt=0, delt=0, dir=RIGHT, frame divider=0.
  - Resulting outputs: x=0, y=0, hs=1, vs=1, visible=1, frame_tick=0.
  - Reset mid-frame restarts the scan at (0,0) on the first edge after release.
- hcnt increments every clk and wraps at H_TOTAL-1 -> 0.
- vcnt increments only on hcnt wrap and wraps at V_TOTAL-1 -> 0. At simultaneous wrap, both go to 0 on the same edge.
- x=hcnt, y=vcnt; these are direct register outputs.
- Decodes from the registered counters are combinational, with zero latency relative to x/y:
  - hs=0 iff H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (656..751)
  - vs=0 iff V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SYNC (490..491)
  - frame_tick=1 iff hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1
- Animation FSM has two states, RIGHT and LEFT. It updates only on a clk edge where frame_tick=1 && en=1, so delt is stable across each whole frame and never tears mid-frame.
- Frame divider: on each qualifying edge, if div==FRAMES_PER_STEP-1 then div=0 and a step occurs; otherwise div++.
- Step in RIGHT: if delt+STEP >= DELT_MAX then delt=DELT_MAX and state=LEFT; else delt=delt+STEP.
- Step in LEFT: if delt <= STEP then delt=0 and state=RIGHT; else delt=delt-STEP.
- Arithmetic is 12-bit internally to avoid overflow. delt never leaves [0, DELT_MAX]. Endpoints are clamped when STEP does not divide DELT_MAX.
- en=0: delt, state and divider hold; scan timing is unaffected. When en is re-asserted, resumption is deterministic from the held state.
- STEP=0 is legal: delt stays at 0 and state stays RIGHT.

Decomposition:
- Package vga_pkg holds:
  - the timing constants and derived H_TOTAL/V_TOTAL
  - coordinate width (11)
  - dir encoding: RIGHT=0, LEFT=1
- Sub-module logo_bounce_ctrl (clk, rst, step_en, delt) holds the divider and the bounce FSM. The top instantiates it with step_en=frame_tick&en.
- Scan counters and sync decode stay in the top.

Test Plan:
- Release reset, run 800 clk -> x counts 0..799 then back to 0, y goes 0->1; hs is low exactly for x=656..751 (96 cycles).
- Run one full frame (420000 clk) -> exactly one frame_tick, at (799,524); vs low exactly on y=490,491; visible count = 307200 cycles.
- en=1, STEP=2, DELT_MAX=80 -> delt=2 after tick 1, 80 after tick 40, 78 after tick 41, 0 after tick 80, 2 after tick 81; delt constant between ticks.
- STEP=3, DELT_MAX=80 -> delt=78 after tick 26, 80 (clamped) after tick 27, 77 after tick 28.
- en=0 across 5 frame_ticks with delt=10, dir=RIGHT -> delt stays 10; re-assert en -> next tick gives 12. With FRAMES_PER_STEP=4, delt steps only on every 4th tick.
- Assert rst asynchronously at (300,200) with delt=40 -> x, y and delt go to 0 and hs=vs=1 without waiting for a clk edge; scan restarts at (0,0) after release.
